// File: rtl/debug_abstract_cmd_ctrl_pkg.sv
// debug_abstract_cmd_ctrl_pkg: cmderr codes, command field positions, regno bounds and FSM states
package debug_abstract_cmd_ctrl_pkg;
  localparam logic [2:0] CMDERR_NONE = 3'd0;
  localparam logic [2:0] CMDERR_BUSY = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
  localparam logic [2:0] CMDERR_OTHER = 3'd7;
  localparam int CMDTYPE_HI = 31;
  localparam int CMDTYPE_LO = 24;
  localparam int AARSIZE_HI = 22;
  localparam int AARSIZE_LO = 20;
  localparam int POSTINC_BIT = 19;
  localparam int POSTEXEC_BIT = 18;
  localparam int TRANSFER_BIT = 17;
  localparam int WRITE_BIT = 16;
  localparam int REGNO_HI = 15;
  localparam int REGNO_LO = 0;
  localparam logic [15:0] REGNO_CSR_HI = 16'h0FFF;
  localparam logic [15:0] REGNO_GPR_LO = 16'h1000;
  localparam logic [15:0] REGNO_GPR_HI = 16'h101F;
  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_ACCESS, ST_DONE} state_t;
endpackage

// File: rtl/debug_abstract_cmd_ctrl_decode.sv
// debug_cmd_decode: combinational decode/legality check of an Access Register command.
// DBG_AAR_POSTINC_EN makes aarpostincrement=1 legal.
module debug_cmd_decode
  import debug_abstract_cmd_ctrl_pkg::*;
(
  input  logic [31:0] cmd,
  output logic        legal,
  output logic        is_gpr,
  output logic        is_csr,
  output logic [11:0] index,
  output logic        write,
  output logic        transfer
);
  logic [15:0] regno;
  logic postinc_ok;
  logic unused_bit;
  assign regno = cmd[REGNO_HI:REGNO_LO];
  assign unused_bit = cmd[23];
`ifdef DBG_AAR_POSTINC_EN
  assign postinc_ok = 1'b1;
`else
  assign postinc_ok = !cmd[POSTINC_BIT];
`endif
  assign is_csr = regno <= REGNO_CSR_HI;
  assign is_gpr = regno >= REGNO_GPR_LO && regno <= REGNO_GPR_HI;
  assign legal = cmd[CMDTYPE_HI:CMDTYPE_LO] == 8'd0 && cmd[AARSIZE_HI:AARSIZE_LO] == 3'd2 &&
                 !cmd[POSTEXEC_BIT] && postinc_ok && (is_csr || is_gpr);
  assign index = regno[11:0];
  assign write = cmd[WRITE_BIT];
  assign transfer = cmd[TRANSFER_BIT];
endmodule

// File: rtl/debug_abstract_cmd_ctrl.sv
// debug_abstract_cmd_ctrl: sequences Access Register abstract commands onto the core GPR/CSR ports.
// DBG_AAR_POSTINC_EN enables aarpostincrement and the regno_o/regno_we_o write-back ports.
module debug_abstract_cmd_ctrl
  import debug_abstract_cmd_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  input  logic [31:0]     cmd_i,
  input  logic [XLEN-1:0] data0_i,
  input  logic [2:0]      cmderr_clr_i,
  input  logic            halted_i,
  output logic            busy_o,
  output logic [2:0]      cmderr_o,
  output logic [XLEN-1:0] data0_o,
  output logic            data0_we_o,
`ifdef DBG_AAR_POSTINC_EN
  output logic [15:0]     regno_o,
  output logic            regno_we_o,
`endif
  output logic            gpr_req_o,
  output logic            gpr_we_o,
  output logic [4:0]      gpr_addr_o,
  output logic [XLEN-1:0] gpr_wdata_o,
  input  logic            gpr_ack_i,
  input  logic [XLEN-1:0] gpr_rdata_i,
  output logic            csr_req_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic            csr_ack_i,
  input  logic            csr_err_i,
  input  logic [XLEN-1:0] csr_rdata_i
);
  state_t state, state_n;
  logic [31:0] cmd_q;
  logic [XLEN-1:0] data0_q;
  logic [7:0] cnt;
  logic [2:0] err;
  logic legal, is_gpr, is_csr, write, transfer, ack, accept, timeout, access;
  logic [11:0] index;
  debug_cmd_decode u_decode (
    .cmd(cmd_q), .legal(legal), .is_gpr(is_gpr), .is_csr(is_csr),
    .index(index), .write(write), .transfer(transfer)
  );
  assign access = state == ST_ACCESS;
  assign busy_o = state != ST_IDLE;
  assign accept = state == ST_IDLE && cmd_valid_i && cmderr_o == CMDERR_NONE;
  assign ack = is_gpr ? gpr_ack_i : csr_ack_i;
  assign timeout = cnt == 8'(ACK_TIMEOUT - 1);
  assign gpr_req_o = access && is_gpr;
  assign gpr_we_o = gpr_req_o && write;
  assign gpr_addr_o = index[4:0];
  assign gpr_wdata_o = data0_q;
  assign csr_req_o = access && is_csr;
  assign csr_we_o = csr_req_o && write;
  assign csr_addr_o = index;
  assign csr_wdata_o = data0_q;
`ifdef DBG_AAR_POSTINC_EN
  assign regno_o = cmd_q[REGNO_HI:REGNO_LO] + 16'd1;
  assign regno_we_o = state == ST_DONE && cmd_q[POSTINC_BIT] && cmderr_o == CMDERR_NONE;
`endif
  always_comb begin
    state_n = state;
    err = CMDERR_NONE;
    case (state)
      ST_IDLE: state_n = accept ? ST_CHECK : ST_IDLE;
      ST_CHECK: begin
        state_n = legal && halted_i && transfer ? ST_ACCESS : ST_DONE;
        err = !legal ? CMDERR_NOTSUP : !halted_i ? CMDERR_HALTRESUME : CMDERR_NONE;
      end
      ST_ACCESS: begin
        state_n = ack || timeout ? ST_DONE : ST_ACCESS;
        err = ack ? (is_csr && csr_err_i ? CMDERR_EXCEPTION : CMDERR_NONE) :
              timeout ? CMDERR_OTHER : CMDERR_NONE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (err == CMDERR_NONE && cmd_valid_i && busy_o) err = CMDERR_BUSY;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cmd_q <= '0;
      data0_q <= '0;
      cnt <= '0;
      cmderr_o <= CMDERR_NONE;
      data0_o <= '0;
      data0_we_o <= 1'b0;
    end else begin
      state <= state_n;
      // a newly raised error beats a same-cycle clear; otherwise W1C
      cmderr_o <= cmderr_o == CMDERR_NONE && err != CMDERR_NONE ? err : cmderr_o & ~cmderr_clr_i;
      cnt <= access ? cnt + 8'd1 : 8'd0;
      data0_we_o <= access && ack && !write && !(is_csr && csr_err_i);
      if (access && ack && !write) data0_o <= is_gpr ? gpr_rdata_i : csr_rdata_i;
      if (accept) begin
        cmd_q <= cmd_i;
        data0_q <= data0_i;
      end
`ifdef DBG_AAR_POSTINC_EN
      if (regno_we_o) cmd_q[REGNO_HI:REGNO_LO] <= regno_o;
`endif
    end
  end
endmodule

// File: tb/tb_debug_abstract_cmd_ctrl.sv
// tb_debug_abstract_cmd_ctrl: scoreboard bench for debug_abstract_cmd_ctrl.
// Honours DBG_AAR_POSTINC_EN when the design is built with it.
module tb_debug_abstract_cmd_ctrl;
  typedef struct {
    bit csr;
    bit we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } req_t;
  logic clk = 0, rst = 1, cmd_valid_i = 0, halted_i = 1;
  logic [31:0] cmd_i = 0, data0_i = 0, gpr_rdata_i = 0, csr_rdata_i = 0;
  logic [2:0] cmderr_clr_i = 0;
  logic gpr_ack_i = 0, csr_ack_i = 0, csr_err_i = 0;
  logic busy_o, data0_we_o, gpr_req_o, gpr_we_o, csr_req_o, csr_we_o;
  logic [2:0] cmderr_o;
  logic [31:0] data0_o, gpr_wdata_o, csr_wdata_o;
  logic [4:0] gpr_addr_o;
  logic [11:0] csr_addr_o;
`ifdef DBG_AAR_POSTINC_EN
  logic [15:0] regno_o;
  logic regno_we_o;
  int regno_strobes = 0;
`endif
  int checks = 0, errors = 0;
  req_t exp_req[$];
  logic [31:0] exp_rd[$];
  logic req_prev = 0;
  int bc, rc;

  debug_abstract_cmd_ctrl #(.ACK_TIMEOUT(16), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i), .data0_i(data0_i),
    .cmderr_clr_i(cmderr_clr_i), .halted_i(halted_i), .busy_o(busy_o), .cmderr_o(cmderr_o),
    .data0_o(data0_o), .data0_we_o(data0_we_o),
`ifdef DBG_AAR_POSTINC_EN
    .regno_o(regno_o), .regno_we_o(regno_we_o),
`endif
    .gpr_req_o(gpr_req_o), .gpr_we_o(gpr_we_o), .gpr_addr_o(gpr_addr_o),
    .gpr_wdata_o(gpr_wdata_o), .gpr_ack_i(gpr_ack_i), .gpr_rdata_i(gpr_rdata_i),
    .csr_req_o(csr_req_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .csr_ack_i(csr_ack_i), .csr_err_i(csr_err_i),
    .csr_rdata_i(csr_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compares every request launch and every DATA0 write against the queues
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (gpr_req_o && csr_req_o) chk("one_port_req", 32'(csr_req_o), 32'(0));
      if ((gpr_req_o || csr_req_o) && !req_prev) begin
        if (exp_req.size() == 0) chk("unexpected_req", 32'(1), 32'(0));
        else begin
          e = exp_req.pop_front();
          chk("req_port_csr", 32'(csr_req_o), 32'(e.csr));
          chk("req_we", 32'(e.csr ? csr_we_o : gpr_we_o), 32'(e.we));
          chk("req_addr", e.csr ? 32'(csr_addr_o) : 32'(gpr_addr_o), 32'(e.addr));
          if (e.we) chk("req_wdata", e.csr ? csr_wdata_o : gpr_wdata_o, e.wdata);
        end
      end
      req_prev = gpr_req_o || csr_req_o;
      if (data0_we_o) begin
        if (exp_rd.size() == 0) chk("unexpected_data0_we", 32'(1), 32'(0));
        else chk("data0_o", data0_o, exp_rd.pop_front());
      end
`ifdef DBG_AAR_POSTINC_EN
      if (regno_we_o) begin
        regno_strobes++;
        chk("regno_o", 32'(regno_o), 32'h1020);
      end
`endif
    end
  end

  task automatic push_req(input bit csr, input bit we, input logic [11:0] addr, input logic [31:0] wd);
    req_t r;
    r.csr = csr; r.we = we; r.addr = addr; r.wdata = wd;
    exp_req.push_back(r);
  endtask

  // ack_after=0 never acks; dup re-strobes cmd_valid_i in the first ACCESS cycle
  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] d0, input int ack_after,
                         input logic [31:0] rd, input bit cerr, input bit dup);
    bit fin = 0;
    @(posedge clk); #1;
    cmd_valid_i = 1; cmd_i = cmd; data0_i = d0;
    @(posedge clk); #1;
    cmd_valid_i = 0;
    bc = 0; rc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_o) begin
        fin = 1;
        break;
      end
      bc++;
      cmd_valid_i = dup && bc == 2;
      if (gpr_req_o || csr_req_o) begin
        rc++;
        if (rc == ack_after) begin
          if (gpr_req_o) begin gpr_ack_i = 1; gpr_rdata_i = rd; end
          else begin csr_ack_i = 1; csr_rdata_i = rd; csr_err_i = cerr; end
        end
      end
      @(posedge clk); #1;
      gpr_ack_i = 0; csr_ack_i = 0; csr_err_i = 0; cmd_valid_i = 0;
    end
    chk("cmd_finished", 32'(fin), 32'(1));
  endtask

  task automatic clear_err();
    @(posedge clk); #1;
    cmderr_clr_i = 3'd7;
    @(posedge clk); #1;
    cmderr_clr_i = 3'd0;
    chk("cmderr_cleared", 32'(cmderr_o), 32'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_cmderr", 32'(cmderr_o), 32'(0));
    chk("rst_reqs", 32'({gpr_req_o, csr_req_o, data0_we_o}), 32'(0));

    push_req(0, 0, 12'd5, 0); exp_rd.push_back(32'hDEADBEEF);
    run_cmd(32'h00221005, 32'h0, 2, 32'hDEADBEEF, 0, 0);
    chk("gpr_rd_busy_cycles", 32'(bc), 32'(4));
    chk("gpr_rd_cmderr", 32'(cmderr_o), 32'(0));

    push_req(1, 1, 12'h300, 32'h1888);
    run_cmd(32'h00230300, 32'h1888, 2, 32'h0, 0, 0);
    chk("csr_wr_busy_cycles", 32'(bc), 32'(4));
    chk("csr_wr_cmderr", 32'(cmderr_o), 32'(0));

    push_req(0, 1, 12'd0, 32'h55);
    run_cmd(32'h00231000, 32'h55, 1, 32'h0, 0, 0);
    chk("x0_wr_cmderr", 32'(cmderr_o), 32'(0));

    halted_i = 0;
    run_cmd(32'h00221005, 32'h0, 1, 32'h0, 0, 0);
    chk("not_halted_busy", 32'(bc), 32'(2));
    chk("not_halted_cmderr", 32'(cmderr_o), 32'(4));
    halted_i = 1;
    run_cmd(32'h00221005, 32'h0, 1, 32'h0, 0, 0);
    chk("ignored_busy", 32'(bc), 32'(0));
    chk("ignored_cmderr", 32'(cmderr_o), 32'(4));
    clear_err();
    push_req(0, 0, 12'd5, 0); exp_rd.push_back(32'h12345678);
    run_cmd(32'h00221005, 32'h0, 1, 32'h12345678, 0, 0);
    chk("after_clear_busy", 32'(bc), 32'(3));

    run_cmd(32'h00321005, 32'h0, 1, 32'h0, 0, 0);
    chk("aarsize3_cmderr", 32'(cmderr_o), 32'(2));
    clear_err();
    run_cmd(32'h00261005, 32'h0, 1, 32'h0, 0, 0);
    chk("postexec_cmderr", 32'(cmderr_o), 32'(2));
    clear_err();
    run_cmd(32'h00221020, 32'h0, 1, 32'h0, 0, 0);
    chk("regno_1020_cmderr", 32'(cmderr_o), 32'(2));
    clear_err();
    run_cmd(32'h00201005, 32'h0, 1, 32'h0, 0, 0);
    chk("no_transfer_busy", 32'(bc), 32'(2));
    chk("no_transfer_cmderr", 32'(cmderr_o), 32'(0));

    push_req(1, 0, 12'h341, 0);
    run_cmd(32'h00220341, 32'h0, 1, 32'hBAD0BAD0, 1, 0);
    chk("csr_err_cmderr", 32'(cmderr_o), 32'(3));
    clear_err();
    push_req(1, 0, 12'h300, 0); exp_rd.push_back(32'h0000A5A5);
    run_cmd(32'h00220300, 32'h0, 3, 32'h0000A5A5, 0, 0);
    chk("csr_rd_busy", 32'(bc), 32'(5));

    push_req(0, 0, 12'd1, 0);
    run_cmd(32'h00221001, 32'h0, 0, 32'h0, 0, 0);
    chk("timeout_req_cycles", 32'(rc), 32'(16));
    chk("timeout_busy", 32'(bc), 32'(18));
    chk("timeout_cmderr", 32'(cmderr_o), 32'(7));
    clear_err();

    push_req(0, 0, 12'd7, 0); exp_rd.push_back(32'hCAFEF00D);
    run_cmd(32'h00221007, 32'h0, 3, 32'hCAFEF00D, 0, 1);
    chk("busy_err_cmderr", 32'(cmderr_o), 32'(1));
    chk("busy_err_busy", 32'(bc), 32'(5));
    clear_err();

`ifdef DBG_AAR_POSTINC_EN
    push_req(0, 0, 12'd31, 0); exp_rd.push_back(32'h31313131);
    run_cmd(32'h002A101F, 32'h0, 1, 32'h31313131, 0, 0);
    chk("postinc_cmderr", 32'(cmderr_o), 32'(0));
    chk("postinc_strobes", 32'(regno_strobes), 32'(1));
    run_cmd(32'h002A1020, 32'h0, 1, 32'h0, 0, 0);
    chk("postinc_wrap_cmderr", 32'(cmderr_o), 32'(2));
`else
    run_cmd(32'h002A101F, 32'h0, 1, 32'h0, 0, 0);
    chk("postinc_disabled_cmderr", 32'(cmderr_o), 32'(2));
`endif
    clear_err();

    push_req(0, 0, 12'd9, 0);
    @(posedge clk); #1;
    cmd_valid_i = 1; cmd_i = 32'h00221009;
    @(posedge clk); #1;
    cmd_valid_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_busy", 32'(busy_o), 32'(0));
    chk("midrst_req", 32'(gpr_req_o), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_data0_we", 32'(data0_we_o), 32'(0));

    chk("exp_req_drained", 32'(exp_req.size()), 32'(0));
    chk("exp_rd_drained", 32'(exp_rd.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
